// File: rtl/cba_pkg.sv
// Shared types and helpers for the nibble-serial carry-bypass adder sequencer.
package cba_pkg;

  localparam int NIBBLE_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // True when every bit of the nibble propagates, so the carry skips the slice.
  function automatic logic prop_all(input logic [NIBBLE_W-1:0] a,
                                    input logic [NIBBLE_W-1:0] b);
    return &(a ^ b);
  endfunction

endpackage

// File: rtl/cba_slice.sv
// Combinational 4-bit carry-bypass adder slice; exports its bypass select.
module cba_slice
  import cba_pkg::*;
(
  input  logic [NIBBLE_W-1:0] a,
  input  logic [NIBBLE_W-1:0] b,
  input  logic                cin,
  output logic [NIBBLE_W-1:0] sum,
  output logic                cout,
  output logic                bypass
);

  logic [NIBBLE_W-1:0] p;
  logic [NIBBLE_W-1:0] g;
  logic [NIBBLE_W:0]   c;

  always_comb begin
    p    = a ^ b;
    g    = a & b;
    c    = '0;
    c[0] = cin;
    c[1] = g[0] | (p[0] & c[0]);
    c[2] = g[1] | (p[1] & c[1]);
    c[3] = g[2] | (p[2] & c[2]);
    c[4] = g[3] | (p[3] & c[3]);
  end

  assign bypass = prop_all(a, b);
  assign sum    = p ^ c[NIBBLE_W-1:0];
  // When all bits propagate the ripple result equals cin; the mux is the bypass path.
  assign cout   = bypass ? cin : c[NIBBLE_W];

endmodule

// File: rtl/cba_seq_ctrl.sv
// Wide adder that reuses one 4-bit carry-bypass slice, one nibble per cycle, LSB first.
// Optional bypass statistic output is enabled by defining CBA_BYPASS_STAT_EN.
module cba_seq_ctrl
  import cba_pkg::*;
#(
  parameter  int NIBBLES = 4,
  localparam int W       = NIBBLE_W * NIBBLES
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [W-1:0]       in_a,
  input  logic [W-1:0]       in_b,
  input  logic               in_cin,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [W-1:0]       out_sum,
  output logic               out_cout,
  output state_e             dbg_state
`ifdef CBA_BYPASS_STAT_EN
  ,
  output logic [NIBBLES-1:0] out_bypass_mask
`endif
);

  localparam int                IDX_W    = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(NIBBLES - 1);

  // Handshakes: a transfer happens on a rising edge where valid and ready are both 1.
  // in_ready/out_valid decode registered state only; in_valid/out_ready never feed them.

  state_e              state;
  state_e              state_nx;
  logic [IDX_W-1:0]    idx;
  logic [W-1:0]        a_reg;
  logic [W-1:0]        b_reg;
  logic [W-1:0]        sum_reg;
  logic                carry_reg;
  logic [IDX_W+1:0]    bit_base;
  logic [NIBBLE_W-1:0] slice_sum;
  logic                slice_cout;
  logic                slice_bypass;
  logic                accept;

  assign bit_base = {idx, 2'b00};
  assign accept   = in_valid && in_ready;

  cba_slice u_slice (
    .a      (a_reg[bit_base +: NIBBLE_W]),
    .b      (b_reg[bit_base +: NIBBLE_W]),
    .cin    (carry_reg),
    .sum    (slice_sum),
    .cout   (slice_cout),
    .bypass (slice_bypass)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (in_valid) state_nx = RUN;
      RUN:     if (idx == LAST_IDX) state_nx = DONE;
      DONE:    if (out_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      idx       <= '0;
      a_reg     <= '0;
      b_reg     <= '0;
      sum_reg   <= '0;
      carry_reg <= 1'b0;
    end else if (accept) begin
      idx       <= '0;
      a_reg     <= in_a;
      b_reg     <= in_b;
      sum_reg   <= '0;
      carry_reg <= in_cin;
    end else if (state == RUN) begin
      sum_reg[bit_base +: NIBBLE_W] <= slice_sum;
      carry_reg                     <= slice_cout;
      if (idx != LAST_IDX) idx <= idx + 1'b1;
    end
  end

`ifdef CBA_BYPASS_STAT_EN
  logic [NIBBLES-1:0] bypass_mask;

  always_ff @(posedge clk) begin
    if (!rst_n)              bypass_mask      <= '0;
    else if (accept)         bypass_mask      <= '0;
    else if (state == RUN)   bypass_mask[idx] <= slice_bypass;
  end

  assign out_bypass_mask = bypass_mask;
`else
  logic bypass_unused;
  assign bypass_unused = slice_bypass;
`endif

  assign in_ready  = rst_n && (state == IDLE);
  assign out_valid = (state == DONE);
  assign out_sum   = (state == DONE) ? sum_reg : '0;
  assign out_cout  = (state == DONE) && carry_reg;
  assign dbg_state = state;

endmodule

// File: tb/tb_cba_seq_ctrl.sv
// Directed self-checking bench for cba_seq_ctrl (NIBBLES=4) using immediate assertions.
module tb_cba_seq_ctrl;
  import cba_pkg::*;

  localparam int N = 4;
  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_a;
  logic [W-1:0] in_b;
  logic         in_cin;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_sum;
  logic         out_cout;
  state_e       dbg_state;
`ifdef CBA_BYPASS_STAT_EN
  logic [N-1:0] out_bypass_mask;
`endif

  int n_assert = 0;
  int n_fail   = 0;
  logic [W:0] exp_q[$];

  cba_seq_ctrl #(.NIBBLES(N)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_cin    (in_cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_cout  (out_cout),
    .dbg_state (dbg_state)
`ifdef CBA_BYPASS_STAT_EN
    ,
    .out_bypass_mask (out_bypass_mask)
`endif
  );

  // Clock / reset
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_valid(output int cyc);
    cyc = 0;
    while (out_valid !== 1'b1 && cyc < 40) begin
      step();
      cyc++;
    end
  endtask

  // Driver: one full operation from IDLE, including the result handshake.
  task automatic do_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic cin, input logic [W-1:0] es, input logic ec,
                       input logic [N-1:0] em);
    int cyc;
    in_a = a; in_b = b; in_cin = cin; in_valid = 1'b1;
    check({tag, "_rdy"}, in_ready, 1);
    step();
    in_valid = 1'b0;
    wait_valid(cyc);
    check({tag, "_lat"}, cyc, N);
    check({tag, "_sum"}, out_sum, es);
    check({tag, "_cout"}, out_cout, ec);
`ifdef CBA_BYPASS_STAT_EN
    check({tag, "_mask"}, out_bypass_mask, em);
`else
    if (em !== em) $display("unreachable");
`endif
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check({tag, "_idle"}, {out_valid, in_ready}, 2'b01);
  endtask

  initial begin
    int cyc;
    logic seen;
    logic [W-1:0] ra, rb;
    logic rc;

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_a = '0; in_b = '0; in_cin = 1'b0;
    step();
    check("rst_rdy_low", in_ready, 0);
    step();
    check("rst_out", {out_valid, out_cout, out_sum}, 0);
    rst_n = 1'b1;
    #1;
    check("rst_rdy_high", in_ready, 1);
    check("rst_state", dbg_state, IDLE);
`ifdef CBA_BYPASS_STAT_EN
    check("rst_mask", out_bypass_mask, 0);
`endif

    do_op("op1234", 16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 4'h0);
    do_op("opffff1", 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 4'hE);
    do_op("opffffc", 16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1, 4'hF);

    // Backpressure with in_valid held high throughout
    in_a = 16'h00F0; in_b = 16'h0F10; in_cin = 1'b1; in_valid = 1'b1;
    step();
    in_a = 16'hAAAA; in_b = 16'h5555; in_cin = 1'b0;
    check("bp_run_rdy", in_ready, 0);
    wait_valid(cyc);
    check("bp_lat", cyc, N);
    check("bp_sum", {out_cout, out_sum}, 17'h01001);
`ifdef CBA_BYPASS_STAT_EN
    check("bp_mask", out_bypass_mask, 4'h4);
`endif
    for (int i = 0; i < 3; i++) begin
      step();
      check("bp_hold", {out_valid, in_ready, out_cout, out_sum}, {1'b1, 1'b0, 1'b0, 16'h1001});
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check("bp_hs", {out_valid, in_ready}, 2'b01);
    step();
    check("bp_next_acc", {in_ready, dbg_state}, {1'b0, RUN});
    in_valid = 1'b0;
    wait_valid(cyc);
    check("bp_next_lat", cyc, N);
    check("bp_next_sum", {out_cout, out_sum}, 17'h0FFFF);
`ifdef CBA_BYPASS_STAT_EN
    check("bp_next_mask", out_bypass_mask, 4'hF);
`endif
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;

    // Reset during RUN at idx=2
    in_a = 16'h1111; in_b = 16'h2222; in_cin = 1'b0; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    step();
    check("mid_state", dbg_state, RUN);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    #1;
    check("mid_rst_out", {out_valid, out_cout, out_sum}, 0);
    check("mid_rst_rdy", in_ready, 1);
`ifdef CBA_BYPASS_STAT_EN
    check("mid_rst_mask", out_bypass_mask, 0);
`endif
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      step();
      seen = seen | out_valid;
    end
    check("mid_no_result", seen, 0);
    do_op("post_rst", 16'h0001, 16'h0001, 1'b0, 16'h0002, 1'b0, 4'h0);

    // Randomised back-to-back ops against a + b + cin
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      ra = 16'($urandom_range(0, 16'hFFFF));
      rb = 16'($urandom_range(0, 16'hFFFF));
      rc = 1'($urandom_range(0, 1));
      exp_q.push_back({1'b0, ra} + {1'b0, rb} + {16'b0, rc});
      in_a = ra; in_b = rb; in_cin = rc; in_valid = 1'b1;
      check("rnd_rdy", in_ready, 1);
      step();
      wait_valid(cyc);
      check("rnd_lat", cyc, N);
      check("rnd_sum", {out_cout, out_sum}, exp_q.pop_front());
      step();
    end
    in_valid = 1'b0;
    out_ready = 1'b0;
    check("rnd_q_empty", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/cba_seq_ctrl.md
# cba_seq_ctrl

Sequencer that performs a wide (4×NIBBLES-bit) addition by time-multiplexing a single 4-bit carry-bypass adder slice, one nibble per cycle, least significant nibble first.

- Carry is registered between nibbles.
- A valid/ready handshake is used on both the operand side and the result side.
- The block sits between operand producers and any consumer that needs wide sums, where area matters more than throughput.

## Interface
Parameters:
- NIBBLES, 4, number of 4-bit nibbles per operand (≥1); operand width W = 4×NIBBLES

Ports:
- clk  in  1  single clock; all state updates on rising edge
- rst_n  in  1  reset, synchronous and active-low
- in_valid  in  1  operand request
- in_ready  out  1  block can accept operands
- in_a  in  W  operand A
- in_b  in  W  operand B
- in_cin  in  1  carry into nibble 0
- out_valid  out  1  result available
- out_ready  in  1  consumer accepts result
- out_sum  out  W  sum
- out_cout  out  1  carry out of top nibble
- out_bypass_mask  out  NIBBLES  only with CBA_BYPASS_STAT_EN; see Configuration

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready: capture in_a, in_b; carry_reg←in_cin; idx←0; sum_reg←0; go to RUN.
- RUN:
  - in_ready=0.
  - Each cycle, the slice adds a=in_a[4idx+3:4idx], b=in_b[4idx+3:4idx], cin=carry_reg.
  - The slice sum is written into sum_reg[4idx+3:4idx]; carry_reg←slice cout; idx←idx+1.
  - When idx==NIBBLES-1, go to DONE instead of incrementing.
- DONE:
  - out_valid=1; out_sum=sum_reg; out_cout=carry_reg.
  - Outputs hold stable while out_ready=0.
  - On out_ready: go to IDLE.
- Only one operation is in flight. Operands are never accepted in RUN or DONE; in_valid is ignored there.
- Arithmetic: out_cout:out_sum = in_a + in_b + in_cin, exactly (W+1 bits), modulo nothing.
- idx width is clog2(NIBBLES), minimum 1. idx never wraps past NIBBLES-1.
- NIBBLES=1: RUN lasts one cycle.
- Reset values:
  - state=IDLE, in_ready=1 after the reset edge (0 while rst_n=0 sampled).
  - out_valid=0, out_sum=0, out_cout=0, out_bypass_mask=0.
  - carry_reg=0, idx=0.
- Reset mid-RUN or mid-DONE: the operation is discarded and no result is emitted.

## Timing
- Accept edge = E0. RUN occupies cycles E0..E(NIBBLES).
- out_valid rises after edge E(NIBBLES): latency NIBBLES cycles from accept to out_valid.
- Result handshake at edge Ex: out_valid=0 and in_ready=1 in the following cycle.
- The next operands are accepted at the earliest edge Ex+1, so peak throughput is one op per NIBBLES+2 cycles.
- in_ready and out_valid are registered-state decodes, with no combinational path from in_valid or out_ready.

## Configuration
- CBA_BYPASS_STAT_EN defined:
  - The out_bypass_mask port exists.
  - Bit k is set when nibble k took the bypass path, i.e. all four propagate bits (a^b) are 1, so the slice cout equals its cin.
  - The mask is cleared on accept, updated during RUN, and held in DONE.
- Not defined: the port and its register are absent; all other behaviour is identical.

## Structure
- Package cba_pkg:
  - NIBBLE_W=4.
  - FSM state enum (IDLE/RUN/DONE).
  - A function returning the nibble propagate-all flag.
- One sub-module: cba_slice, the combinational 4-bit carry-bypass adder (a, b, cin → sum, cout, bypass).
  - It is instantiated exactly once.
  - It exports its bypass select for the statistic.

## Test plan
- NIBBLES=4, a=0x1234, b=0x4321, cin=0 → sum 0x5555, cout 0, out_valid exactly 4 cycles after accept; mask 0x0.
- a=0xFFFF, b=0x0001, cin=0 → sum 0x0000, cout 1; mask 0xE (nibble 0 generates, nibbles 1–3 bypass).
- a=0xFFFF, b=0x0000, cin=1 → sum 0x0000, cout 1, mask 0xF.
- Backpressure: hold out_ready=0 for 3 cycles in DONE.
  - out_sum and out_cout stay stable and in_ready stays 0.
  - A new in_valid during RUN or DONE is not accepted.
  - After the handshake, the next op is accepted at the first edge with in_ready=1.
- Reset: rst_n=0 for one edge during RUN (idx=2).
  - All outputs reset to 0 and in_ready=1.
  - No result is emitted.
  - The following op 0x0001+0x0001 yields 0x0002.
- Randomised back-to-back ops (in_valid held high) vs. a reference model of a+b+cin; NIBBLES=1 and NIBBLES=8 builds also run.
